// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int LONG_BIT    = 16;
    localparam int INSTR_W     = 32;
    localparam int WORD_W      = 16;
    localparam int IMEM_ADDR_W = 20;

endpackage

// File: rtl/fetch_stage_len_decode.sv
// Instruction length decode: bit 0 of the first word marks a 32-bit
// instruction. Also produces the IF/ID-formatted instruction and the
// sequential next PC.
module fetch_len_decode
    import fetch_stage_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc,
    output logic               isLong,
    output logic [1:0]         len,
    output logic [PC_W-1:0]    pcPlus,
    output logic [INSTR_W-1:0] fetchedInstr
);

    // Short instructions keep only the first word, low half zeroed.
    always_comb begin
        isLong       = instr[LONG_BIT];
        len          = isLong ? 2'd2 : 2'd1;
        pcPlus       = pc + PC_W'(len);
        fetchedInstr = isLong ? instr : {instr[INSTR_W-1:WORD_W], WORD_W'(0)};
    end

endmodule

// File: rtl/fetch_stage.sv
// PC / fetch stage: boot vector load, length decode, PC advance and the
// IF/ID pipeline register, with stall, flush, branch redirect and halt.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter bit              BOOT_FROM_MEM = 1'b1,
    parameter logic [31:0]     RESET_PC      = 32'h0000_0000,
    parameter int              PC_W          = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt,
    input  logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_next_pc,
    output logic               ifid_is_long,
    output logic               ifid_valid,
    output logic               halted
);

    fetch_state_t        stateQ, stateD;
    logic [PC_W-1:0]     pcQ, pcD;
    logic [INSTR_W-1:0]  ifidInstrQ, ifidInstrD;
    logic [PC_W-1:0]     ifidPcQ, ifidPcD;
    logic [PC_W-1:0]     ifidNextPcQ, ifidNextPcD;
    logic                ifidIsLongQ, ifidIsLongD;
    logic                ifidValidQ, ifidValidD;

    logic                isLong;
    logic [1:0]          len;
    logic [PC_W-1:0]     pcPlus;
    logic [INSTR_W-1:0]  fetchedInstr;

    fetch_len_decode #(.PC_W(PC_W)) lenDecode (
        .instr        (instr),
        .pc           (pcQ),
        .isLong       (isLong),
        .len          (len),
        .pcPlus       (pcPlus),
        .fetchedInstr (fetchedInstr)
    );

    // State, PC and IF/ID register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ      <= BOOT_FROM_MEM ? BOOT : RUN;
            pcQ         <= BOOT_FROM_MEM ? '0 : PC_W'(RESET_PC);
            ifidInstrQ  <= '0;
            ifidPcQ     <= '0;
            ifidNextPcQ <= '0;
            ifidIsLongQ <= 1'b0;
            ifidValidQ  <= 1'b0;
        end else begin
            stateQ      <= stateD;
            pcQ         <= pcD;
            ifidInstrQ  <= ifidInstrD;
            ifidPcQ     <= ifidPcD;
            ifidNextPcQ <= ifidNextPcD;
            ifidIsLongQ <= ifidIsLongD;
            ifidValidQ  <= ifidValidD;
        end
    end

    // Next state: boot loads the reset vector, run applies halt > branch > flush > stall.
    always_comb begin
        stateD      = stateQ;
        pcD         = pcQ;
        ifidInstrD  = ifidInstrQ;
        ifidPcD     = ifidPcQ;
        ifidNextPcD = ifidNextPcQ;
        ifidIsLongD = ifidIsLongQ;
        ifidValidD  = ifidValidQ;
        case (stateQ)
            BOOT: begin
                pcD        = PC_W'(instr);
                stateD     = RUN;
                ifidValidD = 1'b0;
            end
            RUN: begin
                if (halt) begin
                    stateD     = HALT;
                    ifidValidD = 1'b0;
                end else if (branch_taken) begin
                    pcD        = branch_target;
                    ifidValidD = 1'b0;
                end else if (flush) begin
                    ifidValidD = 1'b0;
                end else if (!stall) begin
                    ifidInstrD  = fetchedInstr;
                    ifidPcD     = pcQ;
                    ifidNextPcD = pcPlus;
                    ifidIsLongD = isLong;
                    ifidValidD  = 1'b1;
                    pcD         = pcPlus;
                end
            end
            HALT: begin
                ifidValidD = 1'b0;
            end
            default: begin
                stateD     = BOOT;
                ifidValidD = 1'b0;
            end
        endcase
    end

    assign pc           = pcQ;
    assign ifid_instr   = ifidInstrQ;
    assign ifid_pc      = ifidPcQ;
    assign ifid_next_pc = ifidNextPcQ;
    assign ifid_is_long = ifidIsLongQ;
    assign ifid_valid   = ifidValidQ;
    assign halted       = (stateQ == HALT);

endmodule
